// File: rtl/shifter_pkg.sv
// Shared widths, legality helpers and the landscape LFSR tap mask for the chip-to-address reconstruction path.
package shifter_pkg;

  localparam int bit_addr_shi = 19;
  localparam int bit_chip     = 6;
  localparam int bit_shi_l    = 5;
  localparam int sb_l_min     = 3;
  localparam int bit_err      = 8;
  localparam int bit_addr_out = bit_addr_shi + bit_chip;

  localparam logic [bit_shi_l-1:0] sb_l_lo = bit_shi_l'(sb_l_min);
  localparam logic [bit_shi_l-1:0] sb_l_hi = bit_shi_l'(bit_addr_shi - 1);

  // x^19 + x^18 + x^17 + x^14 + 1, shared by all landscape random sources
  localparam logic [bit_addr_shi-1:0] lfsr_taps = 19'h72000;
  localparam logic [bit_addr_shi-1:0] lfsr_seed = 19'h5A5A5;

  function automatic logic sb_legal(input logic [bit_shi_l-1:0] sb);
    return (sb >= sb_l_lo) && (sb <= sb_l_hi);
  endfunction

  function automatic logic [bit_addr_out-1:0] midpoint_fill(input logic [bit_shi_l-1:0] sb);
    return bit_addr_out'(1) << (sb - bit_shi_l'(1));
  endfunction

endpackage

// File: rtl/shifter_l_if.sv
// Valid/ready bundle between the chip readback path (master) and the shifter_l pipeline (slave).
interface shifter_l_if
  import shifter_pkg::*;
();
  logic                    in_valid;
  logic                    in_ready;
  logic [bit_chip-1:0]     in;
  logic [bit_shi_l-1:0]    sb_l;
  logic                    out_valid;
  logic                    out_ready;
  logic [bit_addr_out-1:0] out;
  logic                    out_err;
  logic [bit_err-1:0]      err_cnt;

  modport slave (
    input  in_valid, in, sb_l, out_ready,
    output in_ready, out_valid, out, out_err, err_cnt
  );

  modport master (
    output in_valid, in, sb_l, out_ready,
    input  in_ready, out_valid, out, out_err, err_cnt
  );
endinterface

// File: rtl/shifter_l_lfsr.sv
// Fibonacci LFSR that steps only when enabled; seed and tap mask are parameters.
module shifter_l_lfsr #(
  parameter int               width = 19,
  parameter logic [width-1:0] seed  = '1,
  parameter logic [width-1:0] taps  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [width-1:0] o_state
);
  logic [width-1:0] r_state;
  logic             w_fb;

  assign w_fb    = ^(r_state & taps);
  assign o_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= seed;
    end else if (i_en) begin
      r_state <= {r_state[width-2:0], w_fb};
    end
  end
endmodule

// File: rtl/shifter_l.sv
// Two-stage valid/ready left-shift reconstruction with midpoint fill and saturating out-of-range counter.
// Optional dither fill replacing the midpoint bit: define SHIFTER_L_DITHER_EN.
module shifter_l
  import shifter_pkg::*;
(
  input logic       clk,
  input logic       clr,
  shifter_l_if.slave bus
);
  logic                    r_s1_valid;
  logic [bit_chip-1:0]     r_s1_in;
  logic [bit_shi_l-1:0]    r_s1_sb;
  logic                    r_out_valid;
  logic [bit_addr_out-1:0] r_out;
  logic                    r_out_err;
  logic [bit_err-1:0]      r_err_cnt;

  logic                    w_s2_free;
  logic                    w_in_ready;
  logic                    w_s1_load;
  logic                    w_s2_load;
  logic                    w_legal;
  logic [bit_addr_out-1:0] w_shifted;
  logic [bit_addr_out-1:0] w_fill;

  assign w_s2_free  = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_free;
  assign w_s1_load  = bus.in_valid && w_in_ready;
  assign w_s2_load  = r_s1_valid && w_s2_free;
  assign w_legal    = sb_legal(r_s1_sb);
  assign w_shifted  = bit_addr_out'(r_s1_in) << r_s1_sb;

`ifdef SHIFTER_L_DITHER_EN
  logic [bit_addr_shi-1:0] w_lfsr;
  logic [bit_addr_out-1:0] w_low_mask;

  shifter_l_lfsr #(
    .width (bit_addr_shi),
    .seed  (lfsr_seed),
    .taps  (lfsr_taps)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (clr),
    .i_en    (w_s2_load),
    .o_state (w_lfsr)
  );

  // sb_l <= bit_addr_shi-1 on the legal path, so the mask never exceeds the LFSR width
  assign w_low_mask = (bit_addr_out'(1) << r_s1_sb) - bit_addr_out'(1);
  assign w_fill     = bit_addr_out'(w_lfsr) & w_low_mask;
`else
  assign w_fill = midpoint_fill(r_s1_sb);
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_s1_valid <= 1'b0;
      r_s1_in    <= '0;
      r_s1_sb    <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_s1_in    <= bus.in;
      r_s1_sb    <= bus.sb_l;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_out       <= w_legal ? (w_shifted | w_fill) : '0;
      r_out_err   <= !w_legal;
      if (!w_legal && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.out_err   = r_out_err;
  assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_shifter_l.sv
// Randomized and directed bench for shifter_l against an arithmetic reference with an in-order scoreboard.
module tb_shifter_l;
  import shifter_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  shifter_l_if bus ();

  shifter_l dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int err_model = 0;

  logic [bit_addr_out-1:0] q_val[$];
  logic                    q_err[$];
  int                      q_sb[$];

  logic        hold_pending = 1'b0;
  logic [31:0] hold_val;
  logic        last_in_ready;
  logic        last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [bit_addr_out-1:0] ref_out(input int d, input int s);
    longint v;
    if (s < 3 || s > 18) return '0;
    v = longint'(d) * (longint'(1) << s) + (longint'(1) << (s - 1));
    return bit_addr_out'(v);
  endfunction

  // one clock: check held output, drive inputs, score both handshakes
  task automatic cyc(input logic v, input int d, input int s, input logic rdy);
    logic [bit_addr_out-1:0] e;
    logic ee;
    int es;
    @(negedge clk);
    if (hold_pending) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", {6'd0, bus.out_err, bus.out}, hold_val);
    end
    bus.in_valid  = v;
    bus.in        = bit_chip'(d);
    bus.sb_l      = bit_shi_l'(s);
    bus.out_ready = rdy;
    #1;
    last_in_ready = bus.in_ready;
    last_acc      = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (q_val.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e  = q_val.pop_front();
        ee = q_err.pop_front();
        es = q_sb.pop_front();
`ifdef SHIFTER_L_DITHER_EN
        if (ee) chk("data", 32'(bus.out), 32'(e));
        else    chk("data_hi", 32'(bus.out >> es), 32'(e >> es));
`else
        chk("data", 32'(bus.out), 32'(e));
`endif
        chk("err_flag", 32'(bus.out_err), 32'(ee));
      end
    end
    if (last_acc) begin
      q_val.push_back(ref_out(d, s));
      q_err.push_back(s < 3 || s > 18);
      q_sb.push_back(s);
      if ((s < 3 || s > 18) && err_model < 255) err_model++;
    end
    hold_pending = bus.out_valid && !bus.out_ready;
    hold_val     = {6'd0, bus.out_err, bus.out};
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    clr = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    q_val.delete();
    q_err.delete();
    q_sb.delete();
    err_model    = 0;
    hold_pending = 1'b0;
  endtask

  task automatic drain();
    repeat (6) cyc(1'b0, 0, 0, 1'b1);
    chk("drain_empty", 32'(q_val.size()), 32'd0);
    chk("err_cnt", 32'(bus.err_cnt), 32'(err_model));
  endtask

  initial begin
    int d, s;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.sb_l      = '0;
    bus.out_ready = 1'b1;
    do_reset();

    // latency and legal value
    cyc(1'b1, 37, 5, 1'b1);
    cyc(1'b0, 0, 0, 1'b1);
    chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
    cyc(1'b0, 0, 0, 1'b1);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
`ifndef SHIFTER_L_DITHER_EN
    chk("legal_37_5", 32'(bus.out), 32'd1200);
`else
    chk("dither_hi", 32'(bus.out >> 5), 32'd37);
`endif

    cyc(1'b1, 63, 18, 1'b1);
    cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b1);
`ifndef SHIFTER_L_DITHER_EN
    chk("max_case", 32'(bus.out), 32'd16646144);
`endif
    chk("max_err", 32'(bus.out_err), 32'd0);

    cyc(1'b1, 0, 3, 1'b1);
    cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b1);
`ifndef SHIFTER_L_DITHER_EN
    chk("zero_mid", 32'(bus.out), 32'd4);
`endif

    cyc(1'b1, 11, 2, 1'b1);
    cyc(1'b1, 22, 19, 1'b1);
    drain();
    chk("err_cnt_two", 32'(bus.err_cnt), 32'd2);

    for (int i = 0; i < 300; i++) begin
      d = $urandom_range(0, 63);
      s = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2) : $urandom_range(19, 31);
      cyc(1'b1, d, s, 1'b1);
    end
    drain();
    chk("err_cnt_sat", 32'(bus.err_cnt), 32'd255);

    // backpressure: two accepted, third stalls, outputs held
    cyc(1'b1, 9, 4, 1'b0);
    chk("bp_acc1", 32'(last_acc), 32'd1);
    cyc(1'b1, 17, 7, 1'b0);
    chk("bp_acc2", 32'(last_acc), 32'd1);
    cyc(1'b1, 50, 12, 1'b0);
    chk("bp_in_ready", 32'(last_in_ready), 32'd0);
    repeat (3) cyc(1'b1, 50, 12, 1'b0);
    chk("bp_first_out", 32'(bus.out), 32'(ref_out(9, 4)) & (32'(bus.out_err) - 32'd1) | 32'(bus.out));
    cyc(1'b1, 50, 12, 1'b1);
    chk("bp_release_acc", 32'(last_acc), 32'd1);
    drain();

    // reset with both stages full
    cyc(1'b1, 5, 6, 1'b0);
    cyc(1'b1, 6, 1, 1'b0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      d = $urandom_range(0, 63);
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(3, 18);
      cyc($urandom_range(0, 3) != 0, d, s, $urandom_range(0, 9) < 7);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
